// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the button debouncer: default sizing and channel FSM encoding.
// Optional feature macro: BTN_DEBOUNCE_IRQ_PULSE_EN (see btn_debounce_ch).
package btn_debounce_pkg;

    localparam int DEFAULT_NUM_BTN         = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Named view of the same encoding, for waveform viewers and debug code.
    typedef enum logic [1:0] {
        CH_IDLE         = ST_IDLE,
        CH_PRESS_WAIT   = ST_PRESS_WAIT,
        CH_PRESSED      = ST_PRESSED,
        CH_RELEASE_WAIT = ST_RELEASE_WAIT
    } ch_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, four-state debounce FSM with stable-level counter.
// BTN_DEBOUNCE_IRQ_PULSE_EN defined: irq_o is a one-cycle press pulse; otherwise irq_o = level_o.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic btn_i,
    output logic level_o,
    output logic irq_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // NOTE: all clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer into one flop.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign sync = sync_q[1];

    // NOTE: state_d and cnt_d take their hold values first, so every path assigns
    // them and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sync) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!sync) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Level is registered from the current state, so it follows the FSM by one edge.
    assign level_d = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

`ifdef BTN_DEBOUNCE_IRQ_PULSE_EN
    logic pulse_q;

    // Rising edge of the registered level only; RELEASE_WAIT->PRESSED keeps level high.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= level_d & ~level_q;
        end
    end

    assign irq_o = pulse_q;
`else
    assign irq_o = level_q;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Debounces NUM_BTN board buttons and drives per-channel SoC interrupt requests.
// Optional feature macro: BTN_DEBOUNCE_IRQ_PULSE_EN (pulse-mode irq_o).
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NUM_BTN         = DEFAULT_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] irq_o
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i  (clk_i),
            .arst_i (arst_i),
            .btn_i  (btn_i[i]),
            .level_o(btn_level_o[i]),
            .irq_o  (irq_o[i])
        );
    end

endmodule
